// File: rtl/ghost_pkg.sv
// Shared types and constants for the ghost sprite controller.
package ghost_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } ghost_state_t;

   typedef enum logic {
      DIR_POS = 1'b0,
      DIR_NEG = 1'b1
   } dir_t;

   localparam int GHOST_H_SIZE = 128;
   localparam int GHOST_V_SIZE = 128;
   localparam int SCR_W        = 640;
   localparam int SCR_H        = 480;

endpackage

// File: rtl/ghost_bounce_axis.sv
// One axis of the sprite origin: bounces between 0 and MAX in STEP increments.
module bounce_axis #(
   parameter int MAX  = 512,
   parameter int STEP = 2,
   parameter int INIT = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        tick,
   output logic [10:0] pos
);
   import ghost_pkg::*;

   localparam logic [11:0] MAX_W  = 12'(MAX);
   localparam logic [11:0] STEP_W = 12'(STEP);

   logic [11:0] pos_q;
   dir_t        dir_q;

   // Clamp to the limit on the step that would reach or pass it, so the
   // position never leaves [0, MAX] and never wraps.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pos_q <= 12'(INIT);
         dir_q <= DIR_POS;
      end else if (tick) begin
         if (dir_q == DIR_POS) begin
            if (pos_q + STEP_W >= MAX_W) begin
               pos_q <= MAX_W;
               dir_q <= DIR_NEG;
            end else begin
               pos_q <= pos_q + STEP_W;
            end
         end else begin
            if (pos_q <= STEP_W) begin
               pos_q <= 12'd0;
               dir_q <= DIR_POS;
            end else begin
               pos_q <= pos_q - STEP_W;
            end
         end
      end
   end

   assign pos = pos_q[10:0];

endmodule

// File: rtl/ghost_ctrl.sv
// Ghost sprite controller: streams a bitmap into sprite RAM, then bounces the
// sprite origin around the visible screen once per frame.
module ghost_ctrl #(
   parameter int ADDR   = 14,
   parameter int CD     = 1,
   parameter int H_SIZE = 128,
   parameter int V_SIZE = 128,
   parameter int SCR_W  = 640,
   parameter int SCR_H  = 480,
   parameter int STEP   = 2,
   parameter int X_INIT = 0,
   parameter int Y_INIT = 0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            src_valid,
   input  logic [CD-1:0]   src_data,
   output logic            src_ready,
   input  logic            frame_tick,
   input  logic            run_en,
   output logic            we,
   output logic [ADDR-1:0] addr_w,
   output logic [CD-1:0]   pixel_out,
   output logic [10:0]     x0,
   output logic [10:0]     y0,
   output logic            busy,
   output logic            done
);
   import ghost_pkg::*;

   // state | meaning
   // IDLE  | after reset, waiting for start
   // LOAD  | accepting pixels into sprite RAM
   // RUN   | sprite loaded, origin bounces on frame ticks

   localparam int X_MAX = SCR_W - H_SIZE;
   localparam int Y_MAX = SCR_H - V_SIZE;

   ghost_state_t    state;
   logic [ADDR-1:0] load_cnt;
   logic            motion_tick;

   assign src_ready = (state == LOAD);
   assign busy      = (state == LOAD);

   // A start in the same cycle as a frame tick wins; the origin holds.
   assign motion_tick = (state == RUN) && frame_tick && run_en && !start;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         load_cnt  <= '0;
         we        <= 1'b0;
         addr_w    <= '0;
         pixel_out <= '0;
         done      <= 1'b0;
      end else begin
         we   <= 1'b0;
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= LOAD;
                  load_cnt <= '0;
               end
            end
            LOAD: begin
               if (src_valid) begin
                  we        <= 1'b1;
                  addr_w    <= load_cnt;
                  pixel_out <= src_data;
                  load_cnt  <= load_cnt + 1'b1;
                  if (load_cnt == '1) begin
                     done  <= 1'b1;
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               if (start) begin
                  state    <= LOAD;
                  load_cnt <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   bounce_axis #(.MAX(X_MAX), .STEP(STEP), .INIT(X_INIT)) u_axis_x (
      .clk   (clk),
      .reset (reset),
      .tick  (motion_tick),
      .pos   (x0)
   );

   bounce_axis #(.MAX(Y_MAX), .STEP(STEP), .INIT(Y_INIT)) u_axis_y (
      .clk   (clk),
      .reset (reset),
      .tick  (motion_tick),
      .pos   (y0)
   );

endmodule
